alu_decode: RTL

Decode-and-issue stage directly upstream of the ALU. Accepts one RV32I instruction per cycle with its PC and register-file read data, and produces the ALU operands `a`/`b` and the 8-bit ALU control word. It also produces the destination-register info. Results are held in a registered two-entry skid buffer with valid/ready handshakes on both sides. A flush input kills everything in flight.

---
 rtl/alu_decode_pkg.sv | 59 +++++
 rtl/alu_decode_skid_buf.sv | 74 +++++++
 rtl/alu_decode.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_decode_pkg.sv
// Shared definitions for the decode-and-issue stage: opcodes, ALU control
// encodings, control-word field positions and the issue payload.
package alu_decode_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned RD_W   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [CTRL_W-1:0] CTRL_ADD  = 8'h00;
  localparam logic [CTRL_W-1:0] CTRL_SUB  = 8'h82;
  localparam logic [CTRL_W-1:0] CTRL_AND  = 8'h10;
  localparam logic [CTRL_W-1:0] CTRL_OR   = 8'h9A;
  localparam logic [CTRL_W-1:0] CTRL_XOR  = 8'h20;
  localparam logic [CTRL_W-1:0] CTRL_SLL  = 8'h41;
  localparam logic [CTRL_W-1:0] CTRL_SRL  = 8'h42;
  localparam logic [CTRL_W-1:0] CTRL_SRA  = 8'h43;
  localparam logic [CTRL_W-1:0] CTRL_SLT  = 8'h50;
  localparam logic [CTRL_W-1:0] CTRL_SLTU = 8'h51;

  localparam int unsigned CTRL_INV_RES = 7;
  localparam int unsigned CTRL_SEL_MSB = 6;
  localparam int unsigned CTRL_SEL_LSB = 4;
  localparam int unsigned CTRL_INV_B   = 3;
  localparam int unsigned CTRL_INV_A   = 1;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic              rd_we;
    logic              illegal;
  } issue_t;

  localparam int unsigned ISSUE_W = $bits(issue_t);

  // Register-register ALU op from funct3; alt selects SUB / SRA variants.
  function automatic logic [CTRL_W-1:0] alu_ctrl(input logic [2:0] funct3,
                                                 input logic sub, input logic sra);
    logic [CTRL_W-1:0] c;
    case (funct3)
      3'b000:  c = sub ? CTRL_SUB : CTRL_ADD;
      3'b001:  c = CTRL_SLL;
      3'b010:  c = CTRL_SLT;
      3'b011:  c = CTRL_SLTU;
      3'b100:  c = CTRL_XOR;
      3'b101:  c = sra ? CTRL_SRA : CTRL_SRL;
      3'b110:  c = CTRL_OR;
      default: c = CTRL_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decode_skid_buf.sv
// Generic two-entry registered valid/ready buffer; main entry drives the
// output, skid entry absorbs one beat while the consumer stalls.
module skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, consume;

  assign accept    = in_valid && ready_q && !flush;
  assign consume   = main_valid_q && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (consume) begin
        main_valid_d = skid_valid_q;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
      // New entry lands in main if main is free after this cycle, else in skid.
      if (accept) begin
        if (!main_valid_d) begin
          main_valid_d = 1'b1;
          main_d       = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_d       = in_data;
        end
      end
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_decode.sv
// Decode-and-issue stage in front of the ALU: RV32I decode to operands and
// control word, issued through a registered two-entry skid buffer.
module alu_decode
  import alu_decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_rd_we,
  output logic              out_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RD_W-1:0] rd;
  logic            f7_legal;
  logic            is_shift;
  issue_t          dec;
  issue_t          issued;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // funct7 0x20 is only meaningful for the SUB and SRA/SRAI slots.
  assign f7_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  always_comb begin
    dec         = '0;
    dec.rd      = rd;
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7_legal) begin
          dec.a       = in_rs1;
          dec.b       = in_rs2;
          dec.ctrl    = alu_ctrl(funct3, funct7[5], funct7[5]);
          dec.illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (!is_shift || (f7_legal && (funct3 == 3'b101 || funct7 == 7'h00))) begin
          dec.a       = in_rs1;
          dec.b       = is_shift ? XLEN'({27'b0, in_instr[24:20]})
                                 : {{20{in_instr[31]}}, in_instr[31:20]};
          dec.ctrl    = alu_ctrl(funct3, 1'b0, funct7[5]);
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.b       = {in_instr[31:12], 12'b0};
        dec.ctrl    = CTRL_ADD;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a       = in_pc;
        dec.b       = {in_instr[31:12], 12'b0};
        dec.ctrl    = CTRL_ADD;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
    dec.rd_we = !dec.illegal && (rd != 5'd0);
  end

  skid_buf #(.W(ISSUE_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (issued)
  );

  assign out_a       = issued.a;
  assign out_b       = issued.b;
  assign out_ctrl    = issued.ctrl;
  assign out_rd      = issued.rd;
  assign out_rd_we   = issued.rd_we;
  assign out_illegal = issued.illegal;

endmodule
